// File: rtl/des_block_packer_if.sv
// ============================================================================
// Module      : des_block_packer_if
// Description : Byte-in / 64-bit-block-out handshake bundle for the DES
//               block packer. The slave modport is the packer itself; the
//               master modport is the upstream byte source plus the
//               downstream DES stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface des_block_packer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_block;
   logic        out_last;
   logic [3:0]  out_nbytes;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_block, out_last, out_nbytes
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_block, out_last, out_nbytes
   );
endinterface

`default_nettype wire

// File: rtl/des_block_packer.sv
// ============================================================================
// Module      : des_block_packer
// Description : Collects message bytes into 64-bit DES plaintext blocks.
//               A block closes on the 8th byte or on a byte flagged last.
//               Optional PKCS#5 padding is enabled by defining the macro
//               DES_BLOCK_PACKER_PAD_EN; without it, unfilled lanes are zero.
//               MSB_FIRST=1 places the first byte in out_block[63:56].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module des_block_packer #(
   parameter int MSB_FIRST = 1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   des_block_packer_if.slave  bus
);

`ifdef DES_BLOCK_PACKER_PAD_EN
   localparam logic c_pad_en = 1'b1;
`else
   localparam logic c_pad_en = 1'b0;
`endif

   localparam logic [63:0] c_pad_block = 64'h0808080808080808;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      HOLD   = 2'd1,
      PADBLK = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;          // bytes stored so far; bit 3 is the full flag
   logic        r_pend;         // a standalone pad block must follow
   logic [7:0]  r_bytes [8];    // byte buffer indexed by arrival order
   logic        r_in_ready;
   logic        r_out_valid;
   logic [63:0] r_out_block;
   logic        r_out_last;
   logic [3:0]  r_out_nbytes;

   logic        w_accept;
   logic [3:0]  w_k;            // byte count including the byte now arriving
   logic        w_close;
   logic [7:0]  w_pad_val;
   logic        w_last_out;
   logic        w_pend;
   logic [7:0]  w_lane  [8];
   logic [63:0] w_block;

   assign w_accept   = bus.in_valid && r_in_ready;
   assign w_k        = r_cnt + 4'd1;
   assign w_close    = w_accept && (w_k[3] || bus.in_last);
   assign w_pad_val  = c_pad_en ? {4'h0, 4'd8 - w_k} : 8'h00;
   // A last byte that fills the block leaves no room for padding, so the
   // pad travels in its own block and this one is not the final block.
   assign w_last_out = bus.in_last && !(c_pad_en && w_k[3]);
   assign w_pend     = c_pad_en && bus.in_last && w_k[3];

   // Assemble the outgoing block: stored bytes, the arriving byte, then pad
   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign w_lane[i] = (4'(i) < w_k) ?
                         ((4'(i) == r_cnt) ? bus.in_data : r_bytes[i]) :
                         w_pad_val;
      if (MSB_FIRST != 0) begin : g_msb
         assign w_block[63-8*i -: 8] = w_lane[i];
      end else begin : g_lsb
         assign w_block[8*i +: 8] = w_lane[i];
      end
   end

   // Packer state machine with registered handshake and block outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FILL;
         r_cnt        <= 4'd0;
         r_pend       <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_block  <= 64'h0;
         r_out_last   <= 1'b0;
         r_out_nbytes <= 4'd0;
         for (int j = 0; j < 8; j++) begin
            r_bytes[j] <= 8'h00;
         end
      end else begin
         case (r_state)
            FILL: begin
               if (w_accept) begin
                  r_bytes[r_cnt[2:0]] <= bus.in_data;
                  if (w_close) begin
                     r_state      <= HOLD;
                     r_cnt        <= 4'd0;
                     r_pend       <= w_pend;
                     r_in_ready   <= 1'b0;
                     r_out_valid  <= 1'b1;
                     r_out_block  <= w_block;
                     r_out_last   <= w_last_out;
                     r_out_nbytes <= w_k;
                  end else begin
                     r_cnt <= w_k;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  if (r_pend) begin
                     r_state      <= PADBLK;
                     r_pend       <= 1'b0;
                     r_out_block  <= c_pad_block;
                     r_out_last   <= 1'b1;
                     r_out_nbytes <= 4'd0;
                  end else begin
                     r_state     <= FILL;
                     r_cnt       <= 4'd0;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                  end
               end
            end
            PADBLK: begin
               if (bus.out_ready) begin
                  r_state     <= FILL;
                  r_cnt       <= 4'd0;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state     <= FILL;
               r_cnt       <= 4'd0;
               r_pend      <= 1'b0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_block  = r_out_block;
   assign bus.out_last   = r_out_last;
   assign bus.out_nbytes = r_out_nbytes;

endmodule

`default_nettype wire

// File: tb/tb_des_block_packer.sv
// ============================================================================
// Module      : tb_des_block_packer
// Description : Self-checking bench for des_block_packer. Two instances
//               (MSB_FIRST=1 and MSB_FIRST=0) share identical stimulus;
//               expected blocks are queued per instance and popped by a
//               monitor whenever a block handshake is pending.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_des_block_packer;

`ifdef DES_BLOCK_PACKER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   typedef struct packed {
      logic [63:0] blk;
      logic        last;
      logic [3:0]  n;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fix_ready = 1'b1;
   logic rnd_ready = 1'b0;
   logic rnd_val   = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cycle = 0;
   exp_t q_m[$];
   exp_t q_l[$];
   exp_t em_m, em_l;
   logic [7:0] msg_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   always @(posedge clk) rnd_val <= 1'($urandom_range(0, 1));

   des_block_packer_if bus_m ();
   des_block_packer_if bus_l ();

   assign bus_m.out_ready = rnd_ready ? rnd_val : fix_ready;
   assign bus_l.in_valid  = bus_m.in_valid;
   assign bus_l.in_data   = bus_m.in_data;
   assign bus_l.in_last   = bus_m.in_last;
   assign bus_l.out_ready = bus_m.out_ready;

   des_block_packer #(.MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
   des_block_packer #(.MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

   function automatic logic [63:0] swap8(input logic [63:0] b);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = b[63-8*i -: 8];
      return r;
   endfunction

   // expected value given in first-byte-at-MSB order; LSB instance mirrored
   task automatic push_exp(input logic [63:0] b, input logic l, input logic [3:0] n);
      q_m.push_back('{b, l, n});
      q_l.push_back('{swap8(b), l, n});
   endtask

   // reference model of block formation for the message held in msg_q
   task automatic model_message();
      int n, pos, k;
      logic [63:0] b;
      logic lst;
      n = msg_q.size();
      pos = 0;
      while (pos < n) begin
         k   = (n - pos > 8) ? 8 : n - pos;
         lst = (pos + k == n);
         for (int i = 0; i < 8; i++)
            b[63-8*i -: 8] = (i < k) ? msg_q[pos+i] : (PAD ? 8'(8 - k) : 8'h00);
         push_exp(b, lst && !(PAD && k == 8), 4'(k));
         if (PAD && lst && k == 8) push_exp(64'h0808080808080808, 1'b1, 4'd0);
         pos += k;
      end
   endtask

   // monitor: compare every block handshake that will complete at next edge
   always @(negedge clk) begin
      if (!rst && bus_m.out_valid && bus_m.out_ready) begin
         tests++;
         if (q_m.size() == 0) begin
            fails++;
            $display("FAIL msb_block unexpected got blk=%h last=%b n=%0d exp none",
                     bus_m.out_block, bus_m.out_last, bus_m.out_nbytes);
         end else begin
            em_m = q_m.pop_front();
            if ({bus_m.out_block, bus_m.out_last, bus_m.out_nbytes} !== em_m) begin
               fails++;
               $display("FAIL msb_block got blk=%h last=%b n=%0d exp blk=%h last=%b n=%0d",
                        bus_m.out_block, bus_m.out_last, bus_m.out_nbytes,
                        em_m.blk, em_m.last, em_m.n);
            end
         end
      end
      if (!rst && bus_l.out_valid && bus_l.out_ready) begin
         tests++;
         if (q_l.size() == 0) begin
            fails++;
            $display("FAIL lsb_block unexpected got blk=%h last=%b n=%0d exp none",
                     bus_l.out_block, bus_l.out_last, bus_l.out_nbytes);
         end else begin
            em_l = q_l.pop_front();
            if ({bus_l.out_block, bus_l.out_last, bus_l.out_nbytes} !== em_l) begin
               fails++;
               $display("FAIL lsb_block got blk=%h last=%b n=%0d exp blk=%h last=%b n=%0d",
                        bus_l.out_block, bus_l.out_last, bus_l.out_nbytes,
                        em_l.blk, em_l.last, em_l.n);
            end
         end
      end
   end

   // drive one byte; returns 1 time unit after the accepting edge
   task automatic send_byte(input logic [7:0] d, input logic l);
      logic rdy;
      int guard;
      guard = 0;
      bus_m.in_valid = 1'b1;
      bus_m.in_data  = d;
      bus_m.in_last  = l;
      forever begin
         @(negedge clk);
         rdy = bus_m.in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         guard++;
         if (guard > 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout got in_ready=0 exp 1 within 200 cycles");
            break;
         end
      end
      bus_m.in_valid = 1'b0;
      bus_m.in_data  = 8'($urandom);
      bus_m.in_last  = 1'b1;   // junk while invalid, must be ignored
   endtask

   task automatic send_msg();
      for (int i = 0; i < msg_q.size(); i++) send_byte(msg_q[i], i == msg_q.size() - 1);
   endtask

   task automatic send_seq(input logic [7:0] first, input int n, input logic last_on_end);
      for (int i = 0; i < n; i++) send_byte(first + 8'(i), last_on_end && (i == n - 1));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while ((q_m.size() != 0 || q_l.size() != 0) && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      tests++;
      if (q_m.size() != 0 || q_l.size() != 0) begin
         fails++;
         $display("FAIL drain got pending msb=%0d lsb=%0d exp 0", q_m.size(), q_l.size());
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if (bus_m.out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got %b exp 0", bus_m.out_valid);
      end
      tests++;
      if (bus_m.out_last !== 1'b0) begin
         fails++; $display("FAIL reset_out_last got %b exp 0", bus_m.out_last);
      end
      tests++;
      if (bus_m.out_nbytes !== 4'd0) begin
         fails++; $display("FAIL reset_out_nbytes got %0d exp 0", bus_m.out_nbytes);
      end
      tests++;
      if (bus_m.out_block !== 64'h0) begin
         fails++; $display("FAIL reset_out_block got %h exp 0", bus_m.out_block);
      end
      tests++;
      if (bus_m.in_ready !== 1'b1 || bus_l.in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready got %b/%b exp 1/1", bus_m.in_ready, bus_l.in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_last();
      push_exp(64'h0102030405060708, !PAD, 4'd8);
      if (PAD) push_exp(64'h0808080808080808, 1'b1, 4'd0);
      send_seq(8'h01, 8, 1'b1);
      wait_drain();
   endtask

   task automatic test_short();
      push_exp(PAD ? 64'hAABBCC0505050505 : 64'hAABBCC0000000000, 1'b1, 4'd3);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b1);
      wait_drain();
   endtask

   task automatic test_no_last();
      push_exp(64'h0102030405060708, 1'b0, 4'd8);
      send_seq(8'h01, 8, 1'b0);
      wait_drain();
   endtask

   task automatic test_latency();
      push_exp(PAD ? 64'h3C07070707070707 : 64'h3C00000000000000, 1'b1, 4'd1);
      tests++;
      if (bus_m.out_valid !== 1'b0) begin
         fails++; $display("FAIL latency_pre got out_valid=%b exp 0", bus_m.out_valid);
      end
      send_byte(8'h3C, 1'b1);
      tests++;
      if (bus_m.out_valid !== 1'b1) begin
         fails++; $display("FAIL latency_post got out_valid=%b exp 1", bus_m.out_valid);
      end
      wait_drain();
   endtask

   task automatic test_backpressure();
      fix_ready = 1'b0;
      push_exp(64'hA0A1A2A3A4A5A6A7, 1'b0, 4'd8);
      push_exp(PAD ? 64'hEE07070707070707 : 64'hEE00000000000000, 1'b1, 4'd1);
      send_seq(8'hA0, 8, 1'b0);
      bus_m.in_valid = 1'b1;
      bus_m.in_data  = 8'hEE;
      bus_m.in_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++;
         if (bus_m.out_valid !== 1'b1 || bus_m.in_ready !== 1'b0 ||
             bus_m.out_block !== 64'hA0A1A2A3A4A5A6A7 ||
             bus_m.out_last !== 1'b0 || bus_m.out_nbytes !== 4'd8) begin
            fails++;
            $display("FAIL hold_stable got v=%b rdy=%b blk=%h last=%b n=%0d exp v=1 rdy=0 blk=a0a1a2a3a4a5a6a7 last=0 n=8",
                     bus_m.out_valid, bus_m.in_ready, bus_m.out_block,
                     bus_m.out_last, bus_m.out_nbytes);
         end
         @(posedge clk);
         #1;
      end
      fix_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (bus_m.in_ready !== 1'b1) begin
         fails++; $display("FAIL release_in_ready got %b exp 1", bus_m.in_ready);
      end
      @(posedge clk);
      #1;
      bus_m.in_valid = 1'b0;
      bus_m.in_last  = 1'b0;
      wait_drain();
   endtask

   task automatic test_reset_abort();
      send_seq(8'h55, 5, 1'b0);
      pulse_reset();
      push_exp(64'h1112131415161718, 1'b0, 4'd8);
      send_seq(8'h11, 8, 1'b0);
      wait_drain();
      // reset while a block is held
      fix_ready = 1'b0;
      send_seq(8'h90, 8, 1'b0);
      pulse_reset();
      @(negedge clk);
      tests++;
      if (bus_m.out_valid !== 1'b0 || bus_m.in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_hold got v=%b rdy=%b exp v=0 rdy=1", bus_m.out_valid, bus_m.in_ready);
      end
      fix_ready = 1'b1;
      @(posedge clk);
      #1;
      // reset one cycle after a full last block transfers (pad block pending)
      push_exp(64'h2122232425262728, !PAD, 4'd8);
      send_seq(8'h21, 8, 1'b1);
      @(posedge clk);
      #1;
      pulse_reset();
      @(negedge clk);
      tests++;
      if (bus_m.out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_padblk got v=%b exp 0", bus_m.out_valid);
      end
      @(posedge clk);
      #1;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int c0;
      push_exp(64'h4041424344454647, 1'b0, 4'd8);
      push_exp(64'h48494A4B4C4D4E4F, 1'b0, 4'd8);
      c0 = cycle;
      send_seq(8'h40, 16, 1'b0);
      tests++;
      if (cycle - c0 !== 17) begin
         fails++; $display("FAIL throughput got %0d cycles exp 17", cycle - c0);
      end
      wait_drain();
   endtask

   task automatic test_random();
      rnd_ready = 1'b1;
      for (int m = 0; m < 8; m++) begin
         msg_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 19)); i++) msg_q.push_back(8'($urandom));
         model_message();
         send_msg();
         wait_drain();
      end
      rnd_ready = 1'b0;
   endtask

   initial begin
      bus_m.in_valid = 1'b0;
      bus_m.in_data  = 8'h00;
      bus_m.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_full_last();
      test_short();
      test_no_last();
      test_latency();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/des_block_packer.md
DES_BLOCK_PACKER -- requirements
Module: des_block_packer

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning that when 1 the first byte of a block goes to out_block[63:56] (DES bit-1 convention), and when 0 it goes to out_block[7:0].
REQ-002 The block SHALL have one clock and synchronous active-high reset, with ports: clk input 1 (rising-edge clock), then rst input 1 (synchronous active-high reset).
REQ-003 in_valid  input  1  upstream byte valid.
REQ-004 in_ready  output  1  block accepts the byte on this edge.
REQ-005 in_data  input  8  message byte.
REQ-006 in_last  input  1  final byte of message, qualified by in_valid.
REQ-007 out_valid  output  1  out_block holds a complete 64-bit block for the DES core.
REQ-008 out_ready  input  1  downstream DES stage consumes the block.
REQ-009 out_block  output  64  packed plaintext block.
REQ-010 out_last  output  1  block is the final block of the message.
REQ-011 out_nbytes  output  4  count of message (non-pad) bytes in out_block, range 0..8.

Function
REQ-012 A byte SHALL transfer only on a rising edge with in_valid=1 and in_ready=1; a block SHALL transfer only on a rising edge with out_valid=1 and out_ready=1.
REQ-013 The FSM SHALL have states FILL, HOLD and PADBLK.
REQ-014 In FILL: in_ready=1 and out_valid=0; the byte counter cnt (3 bits plus a full flag) SHALL increment on each accepted byte.
REQ-015 The block SHALL go FILL->HOLD on acceptance of the 8th byte or of any byte with in_last=1.
REQ-016 out_valid SHALL rise on the cycle after the accepting edge, giving 1-cycle latency.
REQ-017 In HOLD: in_ready=0; out_block, out_last and out_nbytes SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 From HOLD, on a block transfer, the block SHALL go to PADBLK if a pending-pad flag is set, otherwise to FILL with cnt=0.
REQ-019 In PADBLK: out_valid=1, in_ready=0, out_block=64'h0808080808080808, out_last=1, out_nbytes=0; on a block transfer the block SHALL go to FILL.
REQ-020 A full 8-byte block without in_last SHALL give out_last=0 and out_nbytes=8.
REQ-021 A last byte at position k (1..8) SHALL give out_nbytes=k, with the unfilled byte lanes set per the Configuration section.
REQ-022 in_last on an in_valid cycle with in_ready=0 SHALL have no effect; upstream holds it.
REQ-023 Sustained throughput SHALL be one block per 9 cycles with out_ready tied high (8 FILL plus 1 HOLD), and one extra cycle for PADBLK.
REQ-024 in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL go to FILL with cnt=0 and pending-pad cleared.
REQ-026 Reset values SHALL be: out_valid=0, out_last=0, out_nbytes=0, out_block=64'h0, and in_ready=1 on the cycle after reset is released.
REQ-027 A reset in any state, including a partial block or a held or PADBLK block, SHALL discard all buffered data with no block emitted.

Configuration
REQ-028 With macro DES_BLOCK_PACKER_PAD_EN defined, the block SHALL apply PKCS#5 padding:
- last byte at k<8: the remaining 8-k lanes are filled with value 8-k and out_last=1.
- last byte at k=8: the block is emitted with out_last=0 and pending-pad is set, so the PADBLK block follows.
REQ-029 Without DES_BLOCK_PACKER_PAD_EN, the block SHALL behave as follows:
- the unfilled lanes are 8'h00 and out_last=1 for any k;
- PADBLK is unreachable and pending-pad is never set.

Verification
REQ-030 MSB_FIRST=1, bytes 01..08 with in_last on 08, PAD_EN, out_ready=1 -> block 0102030405060708 (last=0, nbytes=8), then 0808080808080808 (last=1, nbytes=0).
REQ-031 MSB_FIRST=1, bytes AA,BB,CC with in_last on CC -> PAD_EN gives AABBCC0505050505 (last=1, nbytes=3); no PAD_EN gives AABBCC0000000000 (last=1, nbytes=3).
REQ-032 MSB_FIRST=0, bytes 01..08, no last -> out_block=0807060504030201, last=0, nbytes=8.
REQ-033 Full block, out_ready held 0 for 5 cycles -> out_valid=1 and outputs stable throughout, in_ready=0; transfer on the 6th cycle, then in_ready=1 on the next cycle.
REQ-034 rst=1 after 5 of 8 bytes, then 8 fresh bytes 11..18 -> the first emitted block is 1112131415161718 (MSB_FIRST=1) with no residue from the aborted bytes.
REQ-035 Single byte 3C with in_last, PAD_EN -> 3C07070707070707, last=1, nbytes=1, out_valid high exactly one cycle after the accepting edge.
